ws2812_chain_driver: RTL and testbench

Parametrised WS2812B chain driver: streams one GRB frame for a chain of NUM_LEDS pixels from an on/off mask, a 3-bit colour and an 8-bit intensity, then holds the latch (reset) period. Generalises the fixed 12-LED ring driver with:

- configurable chain length and bit timing;
- a start/busy/done handshake;
- a rotation offset, so the ring pattern can be turned without rewriting the mask.

It sits between the controller (mask/intensity source) and the uo_out data pin.

---
 rtl/ws2812_chain_driver_pkg.sv | 21 ++
 rtl/ws2812_chain_driver_if.sv | 13 +
 rtl/ws2812_bit_timer.sv | 41 ++++
 rtl/ws2812_chain_driver.sv | 96 +++++++++
 tb/tb_ws2812_chain_driver.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/ws2812_chain_driver_pkg.sv
// ws2812_chain_driver_pkg: shared types, 50 MHz timing defaults and pixel word helpers
package ws2812_pkg;
  typedef enum logic [1:0] {IDLE, HIGH, LOW, LATCH} state_t;
  localparam int T0H_50M = 20;
  localparam int T1H_50M = 40;
  localparam int TBIT_50M = 63;
  localparam int TRST_50M = 15000;
  localparam int COL_R = 2;
  localparam int COL_G = 1;
  localparam int COL_B = 0;
  typedef logic [23:0] pixel_t;
  function automatic pixel_t pixel_word(input logic on, input logic [2:0] colour, input logic [7:0] intensity);
    return {(on && colour[COL_G]) ? intensity : 8'h00,
            (on && colour[COL_R]) ? intensity : 8'h00,
            (on && colour[COL_B]) ? intensity : 8'h00};
  endfunction
  // single subtraction is enough: callers keep v below 2*n
  function automatic int wrap(input int v, input int n);
    return v >= n ? v - n : v;
  endfunction
endpackage

// File: rtl/ws2812_chain_driver_if.sv
// ws2812_chain_driver_if: frame request, pattern inputs and serial output of the chain driver
interface ws2812_chain_driver_if #(parameter int NUM_LEDS = 12);
  logic start;
  logic [NUM_LEDS-1:0] led_mask;
  logic [$clog2(NUM_LEDS)-1:0] rotate;
  logic [2:0] colour;
  logic [7:0] intensity;
  logic busy;
  logic done;
  logic led_dout;
  modport master (output start, led_mask, rotate, colour, intensity, input busy, done, led_dout);
  modport slave (input start, led_mask, rotate, colour, intensity, output busy, done, led_dout);
endinterface

// File: rtl/ws2812_bit_timer.sv
// ws2812_bit_timer: shapes one WS2812B bit, high for T0H/T1H cycles within a TBIT-cycle slot
module ws2812_bit_timer #(
  parameter int T0H_CYC = 20,
  parameter int T1H_CYC = 40,
  parameter int TBIT_CYC = 63
) (
  input  logic clk,
  input  logic res_n,
  input  logic load,
  input  logic bit_val,
  output logic dout,
  output logic bit_end
);
  localparam int CW = $clog2(TBIT_CYC + 1);
  logic [CW-1:0] cnt;
  logic [CW-1:0] th;
  logic active;
  logic one;
  assign th = one ? CW'(T1H_CYC) : CW'(T0H_CYC);
  assign bit_end = active && cnt == CW'(TBIT_CYC - 1);
  // a load on the bit_end cycle chains the next bit with no gap
  always_ff @(posedge clk) begin
    if (!res_n) begin
      cnt <= '0;
      active <= 1'b0;
      one <= 1'b0;
      dout <= 1'b0;
    end else if (load) begin
      cnt <= '0;
      active <= 1'b1;
      one <= bit_val;
      dout <= 1'b1;
    end else if (bit_end) begin
      active <= 1'b0;
      dout <= 1'b0;
    end else if (active) begin
      cnt <= cnt + CW'(1);
      dout <= (cnt + CW'(1)) < th;
    end
  end
endmodule

// File: rtl/ws2812_chain_driver.sv
// ws2812_chain_driver: streams one GRB frame for a rotatable LED mask, then holds the latch period
module ws2812_chain_driver
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS = 12,
  parameter int T0H_CYC = T0H_50M,
  parameter int T1H_CYC = T1H_50M,
  parameter int TBIT_CYC = TBIT_50M,
  parameter int TRST_CYC = TRST_50M
) (
  input logic clk,
  input logic res_n,
  ws2812_chain_driver_if.slave bus
);
  localparam int PW = $clog2(NUM_LEDS);
  localparam int PHW = $clog2((TBIT_CYC > TRST_CYC ? TBIT_CYC : TRST_CYC) + 1);
  state_t state;
  logic [NUM_LEDS-1:0] mask_s;
  logic [PW-1:0] rot_s, rot_in, pix, npix, sel_pix, sel_rot, idx;
  logic [2:0] colour_s;
  logic [7:0] int_s;
  logic [4:0] bit_cnt, nbit, sel_bit;
  logic [PHW-1:0] phase;
  logic busy, done, dout, bit_end, load, bit_val, idle, last_bit, last;
  pixel_t word;
  // the bit handed to the timer is always the one about to start: from the live inputs
  // when a frame launches, otherwise the successor of the bit now on the wire
  always_comb begin
    idle = state == IDLE;
    last_bit = bit_cnt == 5'd23;
    last = last_bit && pix == PW'(NUM_LEDS - 1);
    npix = last_bit ? pix + PW'(1) : pix;
    nbit = last_bit ? 5'd0 : bit_cnt + 5'd1;
    rot_in = PW'(wrap(int'(bus.rotate), NUM_LEDS));
    sel_pix = idle ? '0 : npix;
    sel_rot = idle ? rot_in : rot_s;
    sel_bit = idle ? 5'd0 : nbit;
    idx = PW'(wrap(int'(sel_pix) + int'(sel_rot), NUM_LEDS));
    word = pixel_word(idle ? bus.led_mask[idx] : mask_s[idx], idle ? bus.colour : colour_s,
                      idle ? bus.intensity : int_s);
    bit_val = word[5'd23 - sel_bit];
    load = idle ? bus.start : (state != LATCH && bit_end && !last);
  end
  ws2812_bit_timer #(.T0H_CYC(T0H_CYC), .T1H_CYC(T1H_CYC), .TBIT_CYC(TBIT_CYC)) u_tmr (
    .clk(clk), .res_n(res_n), .load(load), .bit_val(bit_val), .dout(dout), .bit_end(bit_end)
  );
  always_ff @(posedge clk) begin
    if (!res_n) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      pix <= '0;
      bit_cnt <= '0;
      phase <= '0;
      mask_s <= '0;
      rot_s <= '0;
      colour_s <= '0;
      int_s <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          mask_s <= bus.led_mask;
          rot_s <= rot_in;
          colour_s <= bus.colour;
          int_s <= bus.intensity;
          pix <= '0;
          bit_cnt <= '0;
          phase <= '0;
          busy <= 1'b1;
          state <= HIGH;
        end
        HIGH, LOW: if (bit_end && last) begin
          state <= LATCH;
          phase <= '0;
          done <= TRST_CYC == 1;
        end else if (bit_end) begin
          state <= HIGH;
          pix <= npix;
          bit_cnt <= nbit;
        end else state <= dout ? HIGH : LOW;
        LATCH: if (phase == PHW'(TRST_CYC - 1)) begin
          state <= IDLE;
          busy <= 1'b0;
        end else begin
          phase <= phase + PHW'(1);
          done <= (phase + PHW'(1)) == PHW'(TRST_CYC - 1);
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.led_dout = dout;
endmodule

// File: tb/tb_ws2812_chain_driver.sv
// tb_ws2812_chain_driver: directed frames on a 4-LED chain plus a 12-LED full-white frame
module tb_ws2812_chain_driver;
  logic clk = 1'b0;
  logic res_n = 1'b0;
  int tests = 0;
  int fails = 0;
  logic [95:0] bits;
  int nb, nbusy, done_at, ndone, bad, run_len, t;
  logic prev;
  always #5 clk = ~clk;
  ws2812_chain_driver_if #(.NUM_LEDS(4)) d4 ();
  ws2812_chain_driver_if #(.NUM_LEDS(12)) d12 ();
  ws2812_chain_driver #(.NUM_LEDS(4), .T0H_CYC(2), .T1H_CYC(4), .TBIT_CYC(6), .TRST_CYC(10)) dut4 (
    .clk(clk), .res_n(res_n), .bus(d4)
  );
  ws2812_chain_driver #(.NUM_LEDS(12), .T0H_CYC(2), .T1H_CYC(4), .TBIT_CYC(6), .TRST_CYC(10)) dut12 (
    .clk(clk), .res_n(res_n), .bus(d12)
  );
  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic clear(input int t0);
    bits = '0;
    nb = 0;
    nbusy = 0;
    done_at = -1;
    ndone = 0;
    bad = 0;
    run_len = 0;
    prev = 1'b0;
    t = t0;
  endtask
  // decode pulse widths into bits and check each rise starts a 6-cycle slot
  task automatic run_to(input int last_t);
    while (t <= last_t) begin
      @(negedge clk);
      if (d4.busy) nbusy++;
      if (d4.done) begin
        ndone++;
        done_at = t;
      end
      if (d4.led_dout) begin
        if (!prev && (t - 1) % 6 != 0) bad++;
        run_len++;
      end else if (prev) begin
        if (nb < 96) bits[95 - nb] = run_len == 4;
        nb++;
        if (run_len != 2 && run_len != 4) bad++;
        run_len = 0;
      end
      prev = d4.led_dout;
      t++;
    end
  endtask
  task automatic go();
    @(posedge clk);
    #1 d4.start = 1'b1;
    @(posedge clk);
    #1 d4.start = 1'b0;
    clear(1);
  endtask
  task automatic check_frame(input string tag, input logic [95:0] exp_bits);
    check({tag, "_bits"}, bits, exp_bits);
    check({tag, "_nbits"}, 96'(nb), 96'd96);
    check({tag, "_width"}, 96'(bad), 96'd0);
    check({tag, "_busy_cyc"}, 96'(nbusy), 96'd586);
    check({tag, "_done_at"}, 96'(done_at), 96'd586);
    check({tag, "_ndone"}, 96'(ndone), 96'd1);
  endtask
  initial begin
    int hi, r4, rx, lat, b12, d12_at, d12_n, len;
    logic p;
    d4.start = 1'b0;
    d4.led_mask = 4'b0001;
    d4.rotate = 2'd0;
    d4.colour = 3'b100;
    d4.intensity = 8'hA5;
    d12.start = 1'b0;
    d12.led_mask = 12'hFFF;
    d12.rotate = 4'd13;
    d12.colour = 3'b111;
    d12.intensity = 8'hFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 96'(d4.busy), 96'd0);
    check("rst_dout", 96'(d4.led_dout), 96'd0);
    @(posedge clk);
    #1 res_n = 1'b1;
    hi = 0;
    repeat (20) begin
      @(negedge clk);
      if (d4.busy || d4.done || d4.led_dout) hi++;
    end
    check("idle_quiet", 96'(hi), 96'd0);
    go();
    run_to(600);
    check_frame("single", {24'h00A500, 72'h0});
    d4.rotate = 2'd3;
    go();
    run_to(600);
    check_frame("rot3", {24'h0, 24'h00A500, 48'h0});
    d4.rotate = 2'd2;
    go();
    run_to(100);
    d4.start = 1'b1;
    d4.led_mask = 4'hF;
    run_to(101);
    d4.start = 1'b0;
    run_to(586);
    check_frame("ignore_rot2", {48'h0, 24'h00A500, 24'h0});
    @(posedge clk);
    #1 d4.start = 1'b1;
    @(negedge clk);
    check("gap_busy", 96'(d4.busy), 96'd0);
    check("gap_done", 96'(d4.done), 96'd0);
    @(posedge clk);
    #1 d4.start = 1'b0;
    @(negedge clk);
    check("b2b_busy", 96'(d4.busy), 96'd1);
    check("b2b_dout", 96'(d4.led_dout), 96'd1);
    repeat (291) @(negedge clk);
    check("mid_busy", 96'(d4.busy), 96'd1);
    @(posedge clk);
    #1 res_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_dout", 96'(d4.led_dout), 96'd0);
    check("abort_busy", 96'(d4.busy), 96'd0);
    check("abort_done", 96'(d4.done), 96'd0);
    @(posedge clk);
    #1 res_n = 1'b1;
    clear(1);
    run_to(700);
    check("abort_no_done", 96'(ndone), 96'd0);
    check("abort_no_busy", 96'(nbusy), 96'd0);
    go();
    run_to(600);
    check_frame("after_rst", {4{24'h00A500}});
    @(posedge clk);
    #1 d12.start = 1'b1;
    @(posedge clk);
    #1 d12.start = 1'b0;
    r4 = 0;
    rx = 0;
    lat = 0;
    b12 = 0;
    d12_at = -1;
    d12_n = 0;
    len = 0;
    p = 1'b0;
    for (int k = 1; k <= 1750; k++) begin
      @(negedge clk);
      if (d12.busy) b12++;
      if (d12.done) begin
        d12_n++;
        d12_at = k;
      end
      if (k > 1728 && k <= 1738 && !d12.led_dout) lat++;
      if (d12.led_dout) len++;
      else if (p) begin
        if (len == 4) r4++;
        else rx++;
        len = 0;
      end
      p = d12.led_dout;
    end
    check("white_ones", 96'(r4), 96'd288);
    check("white_other", 96'(rx), 96'd0);
    check("white_latch_low", 96'(lat), 96'd10);
    check("white_busy_cyc", 96'(b12), 96'd1738);
    check("white_done_at", 96'(d12_at), 96'd1738);
    check("white_ndone", 96'(d12_n), 96'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
